pool_engine: RTL and testbench

Parametrised streaming 2D pooling unit: the next generation of the fixed 8-bit max pooler, generalised in data width, image size and window size, with a run-time selectable max/average mode.
- Consumes a raster-order pixel stream: row by row, left to right.
- Emits one pooled result per non-overlapping K×K window; stride equals K.
- Keeps partial window results for one row of windows in an internal partial buffer.
- Sits between a convolution stage's output stream and the next layer's input.

---
 rtl/pool_engine_if.sv | 17 +
 rtl/pool_engine.sv | 104 ++++++++++
 tb/tb_pool_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_engine_if.sv
// Pixel-stream / pooled-result bus for pool_engine.
//   master: upstream driver (ce, in_valid, data_in, mode) and result observer.
//   slave : the pooling engine itself.
interface pool_engine_if #(parameter int DW = 8);
  logic          ce;
  logic          in_valid;
  logic [DW-1:0] data_in;
  logic          mode;
  logic [DW-1:0] data_out;
  logic          valid_op;
  logic          end_op;

  modport master (output ce, in_valid, data_in, mode,
                  input  data_out, valid_op, end_op);
  modport slave  (input  ce, in_valid, data_in, mode,
                  output data_out, valid_op, end_op);
endinterface

// File: rtl/pool_engine.sv
// Streaming non-overlapping KxK pooling (max or average) over a raster-order
// pixel stream. One partial accumulator per window column is kept, so only a
// single row of windows is ever in flight.
//   clk        : clock, rising edge
//   master_rst : async active-high reset, clears all state
//   bus.ce     : clock enable, freezes all state when low
//   bus.in_valid/data_in : pixel stream
//   bus.mode   : 0 = max, 1 = average; latched on each frame's first pixel
//   bus.data_out/valid_op/end_op : pooled result, pulse, last-of-frame pulse
module pool_engine #(
  parameter int DW    = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 12,
  parameter int K     = 2
) (
  input  logic          clk,
  input  logic          master_rst,
  pool_engine_if.slave  bus
);
  localparam int LK   = $clog2(K);
  localparam int ACCW = DW + 2*LK;
  localparam int NG   = IMG_W / K;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;

  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       mode_q, mode_d;
  logic [NG-1:0][ACCW-1:0]    acc_q, acc_d;
  logic [DW-1:0]              dout_q, dout_d;
  logic                       vld_q, vld_d;
  logic                       end_q, end_d;

  logic            first_px, mode_eff, win_first, win_last, col_last, row_last;
  logic [GW-1:0]   g;
  logic [ACCW-1:0] din_x, cur, comb_v;
  logic [DW-1:0]   avg_v;

  always_comb begin
    first_px  = (col_q == '0) && (row_q == '0);
    // The frame's first pixel already pools with the freshly sampled mode.
    mode_eff  = first_px ? bus.mode : mode_q;
    win_first = (col_q[LK-1:0] == '0) && (row_q[LK-1:0] == '0);
    win_last  = (&col_q[LK-1:0]) && (&row_q[LK-1:0]);
    col_last  = (col_q == CW'(IMG_W-1));
    row_last  = (row_q == RW'(IMG_H-1));
    g         = GW'(col_q >> LK);
    din_x     = ACCW'(bus.data_in);
    cur       = acc_q[g];
    if (win_first)     comb_v = din_x;
    else if (mode_eff) comb_v = cur + din_x;
    else               comb_v = (din_x > cur) ? din_x : cur;
    avg_v     = DW'(comb_v >> (2*LK));

    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    vld_d  = vld_q;
    end_d  = end_q;
    // With ce low every flop holds, including a pending result pulse.
    if (bus.ce) begin
      vld_d = 1'b0;
      end_d = 1'b0;
      if (bus.in_valid) begin
        acc_d[g] = comb_v;
        mode_d   = mode_eff;
        col_d    = col_last ? '0 : col_q + CW'(1);
        if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
        if (win_last) begin
          vld_d  = 1'b1;
          dout_d = mode_eff ? avg_v : comb_v[DW-1:0];
          end_d  = col_last && row_last;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.valid_op = vld_q;
  assign bus.end_op   = end_q;
endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine on a 4x4 image, K=2, DW=8.
module tb_pool_engine;
  logic clk;
  logic master_rst;
  pool_engine_if #(.DW(8)) bus ();

  pool_engine #(.DW(8), .IMG_W(4), .IMG_H(4), .K(2)) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       eop;
    int         at;   // accepted-pixel count at which the pulse must appear
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_cnt = 0;
  int   end_cnt = 0;
  int   res_idx = 0;
  logic ce_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted-pixel counter and ce history, sampled at the active edge.
  initial forever begin
    @(posedge clk);
    if (master_rst) acc_cnt = 0;
    else if (bus.ce && bus.in_valid) acc_cnt = acc_cnt + 1;
    ce_prev = bus.ce;
  end

  // Monitor: a new pulse is one produced by an edge that had ce high.
  initial forever begin
    @(negedge clk);
    if (!master_rst && ce_prev && bus.end_op) end_cnt = end_cnt + 1;
    if (!master_rst && ce_prev && bus.valid_op) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_result: got data=%0d end=%0d at=%0d, none expected",
                 bus.data_out, bus.end_op, acc_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.data_out !== e.data || bus.end_op !== e.eop || acc_cnt != e.at) begin
          n_fail = n_fail + 1;
          $display("FAIL result%0d: got data=%0d end=%0d at=%0d, want data=%0d end=%0d at=%0d",
                   res_idx, bus.data_out, bus.end_op, acc_cnt, e.data, e.eop, e.at);
        end
      end
      res_idx = res_idx + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int want);
    n_tests = n_tests + 1;
    if (act != want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d, input logic c);
    bus.in_valid = iv;
    bus.data_in  = d;
    bus.ce       = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int kind, input int i);
    logic [7:0] v;
    case (kind)
      0:       v = 8'(i);
      1:       v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic push1(input logic [7:0] d, input logic eop, input int at);
    exp_t e;
    e.data = d; e.eop = eop; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input int base);
    push1(d0, 1'b0, base + 6);
    push1(d1, 1'b0, base + 8);
    push1(d2, 1'b0, base + 14);
    push1(d3, 1'b1, base + 16);
  endtask

  // mode is driven to m only on the first pixel, inverted afterwards, so a
  // frame's results also show that mid-frame mode changes are ignored.
  task automatic send_frame(input int kind, input logic m, input logic stall, input int npix);
    for (int i = 0; i < npix; i++) begin
      bus.mode = (i == 0) ? m : ~m;
      cyc(1'b1, pix(kind, i), 1'b1);
      if (stall) begin
        if (i == 5) begin
          cyc(1'b1, 8'hAA, 1'b0);
          chk("ce_hold_valid", int'(bus.valid_op), 1);
          chk("ce_hold_data", int'(bus.data_out), 5);
          cyc(1'b1, 8'hAA, 1'b0);
          cyc(1'b1, 8'hAA, 1'b0);
        end
        cyc(1'b0, 8'h55, 1'b1);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int base, e0;
    master_rst   = 1'b1;
    bus.ce       = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.mode     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_valid_op", int'(bus.valid_op), 0);
    chk("rst_end_op", int'(bus.end_op), 0);
    master_rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);

    // Max mode ramp.
    base = acc_cnt;
    push4(8'd5, 8'd7, 8'd13, 8'd15, base);
    send_frame(0, 1'b0, 1'b0, 16);
    wait_drain("drain_max");

    // Average mode ramp.
    base = acc_cnt;
    push4(8'd2, 8'd4, 8'd10, 8'd12, base);
    send_frame(0, 1'b1, 1'b0, 16);
    wait_drain("drain_avg");

    // Stalled max frame: gaps on in_valid plus a ce freeze.
    base = acc_cnt;
    push4(8'd5, 8'd7, 8'd13, 8'd15, base);
    send_frame(0, 1'b0, 1'b1, 16);
    wait_drain("drain_stall");

    // Saturation: all-255 average, then all-0 max.
    base = acc_cnt;
    push4(8'd255, 8'd255, 8'd255, 8'd255, base);
    send_frame(1, 1'b1, 1'b0, 16);
    wait_drain("drain_avg255");
    base = acc_cnt;
    push4(8'd0, 8'd0, 8'd0, 8'd0, base);
    send_frame(2, 1'b0, 1'b0, 16);
    wait_drain("drain_max0");

    // Back-to-back frames, max then average, no idle between.
    base = acc_cnt;
    e0   = end_cnt;
    push4(8'd5, 8'd7, 8'd13, 8'd15, base);
    push4(8'd2, 8'd4, 8'd10, 8'd12, base + 16);
    send_frame(0, 1'b0, 1'b0, 16);
    send_frame(0, 1'b1, 1'b0, 16);
    wait_drain("drain_b2b");
    chk("b2b_end_pulses", end_cnt - e0, 2);

    // Async reset after 6 pixels, then a full clean frame.
    base = acc_cnt;
    push1(8'd5, 1'b0, base + 6);
    send_frame(0, 1'b0, 1'b0, 6);
    @(negedge clk);
    #2;
    master_rst = 1'b1;
    #1;
    chk("async_rst_data_out", int'(bus.data_out), 0);
    chk("async_rst_valid_op", int'(bus.valid_op), 0);
    chk("async_rst_end_op", int'(bus.end_op), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    master_rst = 1'b0;
    chk("pre_restart_queue", exp_q.size(), 0);
    push4(8'd5, 8'd7, 8'd13, 8'd15, 0);
    send_frame(0, 1'b0, 1'b0, 16);
    wait_drain("drain_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
